// File: rtl/axis_pkt_sink_if.sv
// AXI4-Stream slave-side bundle for axis_pkt_sink: data, valid, last in, ready out.
interface axis_pkt_sink_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_sink.sv
// Single-packet AXI4-Stream receiver with random-access readout, release handshake and truncation.
// Optional AXIS_PKT_SINK_STATS_EN adds 16-bit packet and truncation counters.
//
// state | meaning
// IDLE  | one cycle after reset, stream not yet accepted
// RECV  | accepting beats into the buffer
// DROP  | buffer full, draining beats until tlast
// HOLD  | packet presented to consumer, waiting for pkt_ack
module axis_pkt_sink #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              aclk,
    input  logic              areset,
    axis_pkt_sink_if.slave    s,
    output logic              pkt_valid,
    output logic [ADDR_W:0]   pkt_len,
    output logic              pkt_trunc,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              pkt_ack
`ifdef AXIS_PKT_SINK_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       trunc_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              beat;

    assign s.tready = (state == RECV) || (state == DROP);
    assign beat     = s.tvalid && s.tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            wr_cnt    <= '0;
            pkt_valid <= 1'b0;
            pkt_len   <= '0;
            pkt_trunc <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= RECV;
                RECV: begin
                    if (beat) begin
                        if (s.tlast) begin
                            pkt_len   <= {1'b0, wr_cnt} + (ADDR_W+1)'(1);
                            pkt_trunc <= 1'b0;
                            pkt_valid <= 1'b1;
                            state     <= HOLD;
                        end else if (wr_cnt == ADDR_W'(DEPTH-1)) begin
                            // Last slot just written; pkt_len stays at DEPTH while we drain.
                            pkt_len <= (ADDR_W+1)'(DEPTH);
                            state   <= DROP;
                        end else begin
                            wr_cnt <= wr_cnt + ADDR_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (beat && s.tlast) begin
                        pkt_trunc <= 1'b1;
                        pkt_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (pkt_ack) begin
                        pkt_valid <= 1'b0;
                        pkt_len   <= '0;
                        pkt_trunc <= 1'b0;
                        wr_cnt    <= '0;
                        state     <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer is deliberately not reset; stale words beyond pkt_len are visible.
    always_ff @(posedge aclk) begin
        if (state == RECV && beat) mem[wr_cnt] <= s.tdata;
    end

    always_ff @(posedge aclk) begin
        if (areset) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

`ifdef AXIS_PKT_SINK_STATS_EN
    logic enter_hold;
    logic enter_trunc;

    assign enter_hold  = beat && s.tlast && ((state == RECV) || (state == DROP));
    assign enter_trunc = beat && s.tlast && (state == DROP);

    always_ff @(posedge aclk) begin
        if (areset) begin
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
        end else begin
            if (enter_hold)  pkt_cnt   <= pkt_cnt + 16'd1;
            if (enter_trunc) trunc_cnt <= trunc_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Bench for axis_pkt_sink (DEPTH=8): table-driven packets with a scoreboard plus reset/backpressure sequences.
module tb_axis_pkt_sink;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              areset;
    logic              pkt_valid;
    logic [ADDR_W:0]   pkt_len;
    logic              pkt_trunc;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              pkt_ack;
`ifdef AXIS_PKT_SINK_STATS_EN
    logic [15:0]       pkt_cnt;
    logic [15:0]       trunc_cnt;
`endif

    axis_pkt_sink_if #(.DATA_W(DATA_W)) bus ();

    axis_pkt_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .aclk      (clk),
        .areset    (areset),
        .s         (bus),
        .pkt_valid (pkt_valid),
        .pkt_len   (pkt_len),
        .pkt_trunc (pkt_trunc),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pkt_ack   (pkt_ack)
`ifdef AXIS_PKT_SINK_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .trunc_cnt (trunc_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nbeats;
        logic [31:0] base;
        int          exp_len;
        bit          exp_trunc;
    } vec_t;

    typedef struct {
        int          len;
        bit          trunc;
        logic [31:0] base;
    } exp_t;

    vec_t vec[6];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_pkt_cnt   = 0;
    int   exp_trunc_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus.tready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        if (bus.tready !== 1'b1) chk("ready_timeout", bus.tready, 1);
    endtask

    task automatic send_pkt(input int n, input logic [31:0] base, input int elen, input bit etrunc);
        exp_t e;
        e.len   = elen;
        e.trunc = etrunc;
        e.base  = base;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            bus.tvalid = 1'b1;
            bus.tdata  = base + 32'(i);
            bus.tlast  = (i == n - 1);
            wait_ready();
            tick();
        end
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
    endtask

    // Called one cycle after the final beat; reads back the whole packet then releases it.
    task automatic check_pkt();
        exp_t e;
        chk("pkt_valid_rise", pkt_valid, 1);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 1);
            return;
        end
        e = sb.pop_front();
        chk("pkt_len", 32'(pkt_len), 32'(e.len));
        chk("pkt_trunc", pkt_trunc, e.trunc);
        chk("hold_tready", bus.tready, 0);
        exp_pkt_cnt++;
        if (e.trunc) exp_trunc_cnt++;
`ifdef AXIS_PKT_SINK_STATS_EN
        chk("pkt_cnt", pkt_cnt, 32'(exp_pkt_cnt));
        chk("trunc_cnt", trunc_cnt, 32'(exp_trunc_cnt));
`endif
        for (int a = 0; a < e.len; a++) begin
            rd_addr = ADDR_W'(a);
            tick();
            chk("rd_data", rd_data, e.base + 32'(a));
        end
        chk("len_frozen", 32'(pkt_len), 32'(e.len));
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
        chk("ack_valid_clr", pkt_valid, 0);
        chk("ack_len_clr", 32'(pkt_len), 0);
        chk("ack_trunc_clr", pkt_trunc, 0);
        chk("ack_tready", bus.tready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{nbeats: 3,  base: 32'hA0,  exp_len: 3, exp_trunc: 1'b0};
        vec[1] = '{nbeats: 8,  base: 32'h100, exp_len: 8, exp_trunc: 1'b0};
        vec[2] = '{nbeats: 11, base: 32'h0,   exp_len: 8, exp_trunc: 1'b1};
        vec[3] = '{nbeats: 1,  base: 32'h55,  exp_len: 1, exp_trunc: 1'b0};
        vec[4] = '{nbeats: 9,  base: 32'h200, exp_len: 8, exp_trunc: 1'b1};
        vec[5] = '{nbeats: 7,  base: 32'h70,  exp_len: 7, exp_trunc: 1'b0};

        areset     = 1'b1;
        bus.tvalid = 1'b0;
        bus.tdata  = '0;
        bus.tlast  = 1'b0;
        rd_addr    = '0;
        pkt_ack    = 1'b0;
        repeat (3) tick();
        areset = 1'b0;

        chk("rst_tready", bus.tready, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_pkt_len", 32'(pkt_len), 0);
        chk("rst_pkt_trunc", pkt_trunc, 0);
        chk("rst_rd_data", rd_data, 0);
`ifdef AXIS_PKT_SINK_STATS_EN
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_trunc_cnt", trunc_cnt, 0);
`endif
        tick();
        chk("idle_to_recv_tready", bus.tready, 1);
        chk("recv_pkt_valid", pkt_valid, 0);

        for (int i = 0; i < 6; i++) begin
            send_pkt(vec[i].nbeats, vec[i].base, vec[i].exp_len, vec[i].exp_trunc);
            check_pkt();
        end

        // Backpressure: stream stays valid through HOLD; no beat until after the ack.
        send_pkt(2, 32'h300, 2, 1'b0);
        bus.tvalid = 1'b1;
        bus.tdata  = 32'hDEAD;
        bus.tlast  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_tready", bus.tready, 0);
            tick();
            chk("bp_len_frozen", 32'(pkt_len), 2);
        end
        check_pkt();
        begin
            exp_t e;
            e.len = 1; e.trunc = 1'b0; e.base = 32'hDEAD;
            sb.push_back(e);
        end
        tick();
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        check_pkt();

        // Reset in the middle of a 5-beat packet.
        for (int i = 0; i < 2; i++) begin
            bus.tvalid = 1'b1;
            bus.tdata  = 32'h400 + 32'(i);
            bus.tlast  = 1'b0;
            wait_ready();
            tick();
        end
        bus.tvalid = 1'b0;
        areset     = 1'b1;
        tick();
        areset        = 1'b0;
        exp_pkt_cnt   = 0;
        exp_trunc_cnt = 0;
        chk("midrst_pkt_valid", pkt_valid, 0);
        chk("midrst_tready_idle", bus.tready, 0);
        chk("midrst_pkt_len", 32'(pkt_len), 0);
        tick();
        chk("midrst_tready_recv", bus.tready, 1);
        chk("midrst_pkt_valid2", pkt_valid, 0);
        send_pkt(3, 32'h500, 3, 1'b0);
        check_pkt();

        chk("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
